hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
Second-generation pipeline hazard controller for the 5-stage RV32 core with branch prediction. It keeps MEM/WB forwarding and misprediction/jump flush. It adds a parametrised multi-cycle load-use stall and a stall handshake for a multi-cycle MUL/DIV unit in EX. It also adds saturating performance counters. It sits beside the pipeline registers and drives their stall, bubble and flush controls.

Parameters:
REG_AW, 5, register-index width
LOAD_LAT, 1, stall cycles for a load-use dependency (1..7)
CNT_W, 32, performance-counter width (saturating)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
rs1_ID, rs2_ID  in  REG_AW  source registers in ID
rs1_EX, rs2_EX  in  REG_AW  source registers in EX
rd_EX  in  REG_AW  destination in EX
valid_EX  in  1  EX holds a real instruction (not a bubble)
load_EX  in  1  EX instruction is a load
md_req_EX  in  1  EX instruction is a multi-cycle MUL/DIV
md_done  in  1  MUL/DIV result valid this cycle
branch_EX, prediction_EX, btaken_EX, jal_EX, jalr_EX  in  1  branch/jump status in EX
rd_MEM  in  REG_AW;  regwrite_MEM  in  1  MEM writeback info
rd_WB  in  REG_AW;  regwrite_WB  in  1  WB writeback info
forward_A, forward_B  out  2  10 = from MEM, 01 = from WB, 00 = register file
stall_IF, stall_ID  out  1  hold PC and IF/ID
stall_EX  out  1  hold ID/EX
bubble_EX  out  1  load NOP into ID/EX
bubble_MEM  out  1  load NOP into EX/MEM
flush  out  1  squash IF/ID and ID/EX
misprediction  out  1  conditional-branch mispredict
cnt_stall, cnt_flush, cnt_mispred  out  CNT_W  saturating event counters

Behaviour:
- Forwarding (combinational, every state):
  - MEM has priority over WB.
  - A source matches only when regwrite=1, rd!=0 and rd equals the EX source.
- misprediction = valid_EX & branch_EX & (prediction_EX != btaken_EX).
- flush_req = valid_EX & (misprediction | jal_EX | jalr_EX).
- luse = valid_EX & load_EX & rd_EX!=0 & (rd_EX==rs1_ID | rd_EX==rs2_ID).
- FSM states IDLE, LOAD_WAIT, MD_WAIT. Reset: state=IDLE, cnt=0, all counters 0, all control outputs 0.
- IDLE, priority order:
  - flush_req: flush=1 for exactly this cycle, no stall; state stays IDLE. A flush overrides luse, because the ID instruction is wrong-path.
  - Else md_req_EX & !md_done: stall_IF=stall_ID=stall_EX=1, bubble_MEM=1; go to MD_WAIT.
  - Else luse: stall_IF=stall_ID=1, bubble_EX=1. If LOAD_LAT>1, load cnt=LOAD_LAT-1 and go to LOAD_WAIT; otherwise stay IDLE.
  - md_req_EX & md_done in the same cycle: no stall.
- LOAD_WAIT:
  - stall_IF=stall_ID=1, bubble_EX=1; cnt decrements each cycle.
  - When cnt==1, return to IDLE at the next edge.
  - Total stall = LOAD_LAT cycles.
  - flush_req is ignored (EX holds a bubble).
- MD_WAIT:
  - While md_done=0, stall_IF=stall_ID=stall_EX=1 and bubble_MEM=1.
  - In the cycle md_done=1, all stall/bubble outputs are 0 and the next state is IDLE. The instruction advances that same edge.
- Control outputs are combinational from state and inputs. Latency from detection to control is 0 cycles.
- Counters:
  - cnt_stall +1 on any cycle with stall_IF=1.
  - cnt_flush +1 per flush cycle.
  - cnt_mispred +1 per misprediction cycle.
  - All counters saturate at 2^CNT_W-1.
- Reset asserted mid-LOAD_WAIT or mid-MD_WAIT: IDLE next cycle, all outputs 0.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_e enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
  - hz_state_e enum (IDLE, LOAD_WAIT, MD_WAIT).
  - LOAD_LAT_MAX=7.
- One sub-module, sat_counter (parameter W; ports clk, reset, inc, count), instantiated three times.

Test Plan:
- Forwarding: rd_MEM=rd_WB=5, both regwrite=1, rs1_EX=5 → forward_A=10. Then regwrite_MEM=0 → forward_A=01. rd=0 → 00.
- Load-use with LOAD_LAT=3: load rd_EX=7, rs2_ID=7 → stall_IF=1 and bubble_EX=1 for exactly 3 cycles; cnt_stall=3.
- Flush beats stall: load-use plus jal_EX=1 in the same cycle → flush=1, stall_IF=0; state stays IDLE; cnt_flush=1.
- Mispredict: branch_EX=1, prediction_EX=1, btaken_EX=0 → misprediction=1 and flush=1 for 1 cycle; cnt_mispred=1. A predicted-correct branch → no flush.
- MUL/DIV: md_req_EX=1, md_done rises after 4 cycles → stall_EX=1 and bubble_MEM=1 for 4 cycles, 0 on the done cycle; md_done=1 in the first cycle → no stall.
- Reset during MD_WAIT → next cycle all outputs 0, state IDLE. Saturation with CNT_W=2: 5 stall cycles → cnt_stall=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and limits for the multi-cycle hazard controller.
//   fwd_sel_e  : operand source select driven onto forward_A / forward_B
//   hz_state_e : controller state (idle, multi-cycle load stall, MUL/DIV wait)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        MD_WAIT   = 2'b10
    } hz_state_e;

    localparam int unsigned LOAD_LAT_MAX = 7;
    // Wide enough to hold LOAD_LAT_MAX - 1 remaining load-stall cycles.
    localparam int unsigned LCNT_W = $clog2(LOAD_LAT_MAX + 1);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk, reset : clock and synchronous active-high reset (clears to 0)
//   inc        : count one event this cycle
//   count      : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage RV32 core.
//   Inputs : ID/EX source registers, EX destination and instruction class,
//            branch/jump resolution in EX, MEM/WB writeback info, md_done
//            from the multi-cycle MUL/DIV unit.
//   Outputs: forward_A/B operand selects, stall/bubble/flush controls for the
//            pipeline registers, misprediction flag and three saturating
//            event counters (stall, flush, mispredict).
// Controls are combinational from state and inputs; state holds only the
// multi-cycle load stall countdown and the MUL/DIV wait.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rs1_EX,
    input  logic [REG_AW-1:0] rs2_EX,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              valid_EX,
    input  logic              load_EX,
    input  logic              md_req_EX,
    input  logic              md_done,
    input  logic              branch_EX,
    input  logic              prediction_EX,
    input  logic              btaken_EX,
    input  logic              jal_EX,
    input  logic              jalr_EX,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic              regwrite_MEM,
    input  logic [REG_AW-1:0] rd_WB,
    input  logic              regwrite_WB,
    output logic [1:0]        forward_A,
    output logic [1:0]        forward_B,
    output logic              stall_IF,
    output logic              stall_ID,
    output logic              stall_EX,
    output logic              bubble_EX,
    output logic              bubble_MEM,
    output logic              flush,
    output logic              misprediction,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_flush,
    output logic [CNT_W-1:0]  cnt_mispred
);

    if (LOAD_LAT < 1 || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_load_lat
        $error("LOAD_LAT must be in 1..LOAD_LAT_MAX");
    end

    hz_state_e         state_q, state_d;
    logic [LCNT_W-1:0] cnt_q, cnt_d;

    logic mispred, flush_req, luse;
    logic stall_fe, stall_ex, bub_ex, bub_mem, flush_o;

    // MEM wins over WB since it carries the younger write to the same register.
    function automatic fwd_sel_e fwd_for(input logic [REG_AW-1:0] rs);
        if (regwrite_MEM && (rd_MEM != '0) && (rd_MEM == rs)) return FWD_MEM;
        if (regwrite_WB && (rd_WB != '0) && (rd_WB == rs)) return FWD_WB;
        return FWD_RF;
    endfunction

    assign forward_A = fwd_for(rs1_EX);
    assign forward_B = fwd_for(rs2_EX);

    assign mispred   = valid_EX && branch_EX && (prediction_EX != btaken_EX);
    assign flush_req = valid_EX && (mispred || jal_EX || jalr_EX);
    assign luse      = valid_EX && load_EX && (rd_EX != '0) &&
                       ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_fe = 1'b0;
        stall_ex = 1'b0;
        bub_ex   = 1'b0;
        bub_mem  = 1'b0;
        flush_o  = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    // Flush first: whatever sits in ID is wrong-path anyway.
                    if (flush_req) begin
                        flush_o = 1'b1;
                    end else if (md_req_EX && !md_done) begin
                        stall_fe = 1'b1;
                        stall_ex = 1'b1;
                        bub_mem  = 1'b1;
                        state_d  = MD_WAIT;
                    end else if (luse) begin
                        stall_fe = 1'b1;
                        bub_ex   = 1'b1;
                        if (LOAD_LAT > 1) begin
                            cnt_d   = LCNT_W'(LOAD_LAT - 1);
                            state_d = LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    // EX holds a bubble here, so flush_req cannot be genuine.
                    stall_fe = 1'b1;
                    bub_ex   = 1'b1;
                    cnt_d    = cnt_q - LCNT_W'(1);
                    if (cnt_q == LCNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                MD_WAIT: begin
                    if (!md_done) begin
                        stall_fe = 1'b1;
                        stall_ex = 1'b1;
                        bub_mem  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_IF      = stall_fe;
    assign stall_ID      = stall_fe;
    assign stall_EX      = stall_ex;
    assign bubble_EX     = bub_ex;
    assign bubble_MEM    = bub_mem;
    assign flush         = flush_o;
    assign misprediction = mispred && !reset;

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_fe),
        .count (cnt_stall)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_o),
        .count (cnt_flush)
    );

    sat_counter #(.W(CNT_W)) u_cnt_mispred (
        .clk   (clk),
        .reset (reset),
        .inc   (misprediction),
        .count (cnt_mispred)
    );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: vector table, hand-written multi-cycle sequences
// and randomized stimulus against a behavioural model.
// Main DUT: LOAD_LAT=3, CNT_W=16. Second DUT: LOAD_LAT=1, CNT_W=2 (saturation).
module tb_hazard_ctrl_mc;

    localparam int unsigned LAT = 3;
    localparam int unsigned CW  = 16;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
    logic valid_EX, load_EX, md_req_EX, md_done, branch_EX, prediction_EX, btaken_EX;
    logic jal_EX, jalr_EX, regwrite_MEM, regwrite_WB;

    logic [1:0] forward_A, forward_B;
    logic stall_IF, stall_ID, stall_EX, bubble_EX, bubble_MEM, flush, misprediction;
    logic [CW-1:0] cnt_stall, cnt_flush, cnt_mispred;

    logic [1:0] s_fa, s_fb;
    logic s_sif, s_sid, s_sex, s_bex, s_bmem, s_flush, s_mis;
    logic [1:0] s_cnt_stall, s_cnt_flush, s_cnt_mispred;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .valid_EX(valid_EX), .load_EX(load_EX), .md_req_EX(md_req_EX), .md_done(md_done),
        .branch_EX(branch_EX), .prediction_EX(prediction_EX), .btaken_EX(btaken_EX),
        .jal_EX(jal_EX), .jalr_EX(jalr_EX),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM), .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .forward_A(forward_A), .forward_B(forward_B),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
        .bubble_EX(bubble_EX), .bubble_MEM(bubble_MEM), .flush(flush),
        .misprediction(misprediction),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush), .cnt_mispred(cnt_mispred)
    );

    hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
        .valid_EX(valid_EX), .load_EX(load_EX), .md_req_EX(md_req_EX), .md_done(md_done),
        .branch_EX(branch_EX), .prediction_EX(prediction_EX), .btaken_EX(btaken_EX),
        .jal_EX(jal_EX), .jalr_EX(jalr_EX),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM), .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .forward_A(s_fa), .forward_B(s_fb),
        .stall_IF(s_sif), .stall_ID(s_sid), .stall_EX(s_sex),
        .bubble_EX(s_bex), .bubble_MEM(s_bmem), .flush(s_flush),
        .misprediction(s_mis),
        .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush), .cnt_mispred(s_cnt_mispred)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_load_left;   // load-stall cycles still owed after the current one
    bit m_md;          // waiting for MUL/DIV completion
    int m_cs, m_cf, m_cm;
    logic [1:0] e_fa, e_fb;
    bit e_sif, e_sex, e_bex, e_bmem, e_flush, e_mis, e_freq, e_luse;

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (regwrite_MEM && rd_MEM != 0 && rd_MEM == rs) return 2'b10;
        if (regwrite_WB && rd_WB != 0 && rd_WB == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_load_left = 0; m_md = 0; m_cs = 0; m_cf = 0; m_cm = 0;
    endtask

    task automatic model_expect();
        e_fa = m_fwd(rs1_EX);
        e_fb = m_fwd(rs2_EX);
        e_mis = valid_EX && branch_EX && (prediction_EX != btaken_EX);
        e_freq = valid_EX && (e_mis || jal_EX || jalr_EX);
        e_luse = valid_EX && load_EX && rd_EX != 0 && (rd_EX == rs1_ID || rd_EX == rs2_ID);
        e_sif = 0; e_sex = 0; e_bex = 0; e_bmem = 0; e_flush = 0;
        if (reset) e_mis = 0;
        else if (m_load_left > 0) begin e_sif = 1; e_bex = 1; end
        else if (m_md) begin
            if (!md_done) begin e_sif = 1; e_sex = 1; e_bmem = 1; end
        end
        else if (e_freq) e_flush = 1;
        else if (md_req_EX && !md_done) begin e_sif = 1; e_sex = 1; e_bmem = 1; end
        else if (e_luse) begin e_sif = 1; e_bex = 1; end
    endtask

    task automatic model_step();
        if (reset) begin
            model_clear();
        end else begin
            if (e_sif && m_cs < CMAX) m_cs++;
            if (e_flush && m_cf < CMAX) m_cf++;
            if (e_mis && m_cm < CMAX) m_cm++;
            if (m_load_left > 0) m_load_left--;
            else if (m_md) m_md = !md_done;
            else if (e_freq) ;
            else if (md_req_EX && !md_done) m_md = 1;
            else if (e_luse) m_load_left = LAT - 1;
        end
    endtask

    // Compare main DUT against the model for the current inputs, then advance one edge.
    task automatic tick();
        #1;
        model_expect();
        chk("m_fwdA", 32'(forward_A), 32'(e_fa));
        chk("m_fwdB", 32'(forward_B), 32'(e_fb));
        chk("m_stall_IF", 32'(stall_IF), 32'(e_sif));
        chk("m_stall_ID", 32'(stall_ID), 32'(e_sif));
        chk("m_stall_EX", 32'(stall_EX), 32'(e_sex));
        chk("m_bubble_EX", 32'(bubble_EX), 32'(e_bex));
        chk("m_bubble_MEM", 32'(bubble_MEM), 32'(e_bmem));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_mispred", 32'(misprediction), 32'(e_mis));
        chk("m_cnt_stall", 32'(cnt_stall), 32'(m_cs));
        chk("m_cnt_flush", 32'(cnt_flush), 32'(m_cf));
        chk("m_cnt_mispred", 32'(cnt_mispred), 32'(m_cm));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_ID = 0; rs2_ID = 0; rs1_EX = 0; rs2_EX = 0; rd_EX = 0; rd_MEM = 0; rd_WB = 0;
        valid_EX = 0; load_EX = 0; md_req_EX = 0; md_done = 0; branch_EX = 0;
        prediction_EX = 0; btaken_EX = 0; jal_EX = 0; jalr_EX = 0;
        regwrite_MEM = 0; regwrite_WB = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        model_clear();
        chk("rst_stall_IF", 32'(stall_IF), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_cnt_stall", 32'(cnt_stall), 0);
        chk("rst_cnt_flush", 32'(cnt_flush), 0);
        reset = 0;
    endtask

    // ---------------- vector table ----------------
    // ctl: [8]valid [7]load [6]md_req [5]md_done [4]branch [3]pred [2]taken [1]jal [0]jalr
    // ectl: [5]stall_IF [4]stall_EX [3]bubble_EX [2]bubble_MEM [1]flush [0]misprediction
    typedef struct {
        string      name;
        logic [4:0] rs1_ex, rs2_ex, rd_mem;
        logic       rw_mem;
        logic [4:0] rd_wb;
        logic       rw_wb;
        logic [4:0] rd_ex, rs1_id, rs2_id;
        logic [8:0] ctl;
        logic [1:0] e_fa, e_fb;
        logic [5:0] ectl;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_vec(input vec_t v);
        rs1_EX = v.rs1_ex; rs2_EX = v.rs2_ex; rd_MEM = v.rd_mem; regwrite_MEM = v.rw_mem;
        rd_WB = v.rd_wb; regwrite_WB = v.rw_wb; rd_EX = v.rd_ex; rs1_ID = v.rs1_id;
        rs2_ID = v.rs2_id;
        {valid_EX, load_EX, md_req_EX, md_done, branch_EX, prediction_EX, btaken_EX,
         jal_EX, jalr_EX} = v.ctl;
    endtask

    initial begin
        vecs[0]  = '{"fwd_mem",       5, 0, 5, 1, 5, 1, 0, 0, 0, 9'b000000000, 2'b10, 2'b00, 6'b000000};
        vecs[1]  = '{"fwd_wb",        5, 0, 5, 0, 5, 1, 0, 0, 0, 9'b000000000, 2'b01, 2'b00, 6'b000000};
        vecs[2]  = '{"fwd_rd0",       0, 0, 0, 1, 0, 1, 0, 0, 0, 9'b000000000, 2'b00, 2'b00, 6'b000000};
        vecs[3]  = '{"fwd_split",     3, 4, 4, 1, 3, 1, 0, 0, 0, 9'b000000000, 2'b01, 2'b10, 6'b000000};
        vecs[4]  = '{"mispred",       0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100011000, 2'b00, 2'b00, 6'b000011};
        vecs[5]  = '{"pred_ok",       0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100011100, 2'b00, 2'b00, 6'b000000};
        vecs[6]  = '{"flush_vs_luse", 0, 0, 0, 0, 0, 0, 7, 0, 7, 9'b110000010, 2'b00, 2'b00, 6'b000010};
        vecs[7]  = '{"jalr",          0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b100000001, 2'b00, 2'b00, 6'b000010};
        vecs[8]  = '{"md_done_now",   0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b101100000, 2'b00, 2'b00, 6'b000000};
        vecs[9]  = '{"jal_bubble",    0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000000010, 2'b00, 2'b00, 6'b000000};
        vecs[10] = '{"luse_rd0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b110000000, 2'b00, 2'b00, 6'b000000};
        vecs[11] = '{"mispred_inv",   0, 0, 0, 0, 0, 0, 0, 0, 0, 9'b000011000, 2'b00, 2'b00, 6'b000000};

        do_reset();

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #1;
            chk({vecs[i].name, "_fwdA"}, 32'(forward_A), 32'(vecs[i].e_fa));
            chk({vecs[i].name, "_fwdB"}, 32'(forward_B), 32'(vecs[i].e_fb));
            chk({vecs[i].name, "_ctl"},
                32'({stall_IF, stall_EX, bubble_EX, bubble_MEM, flush, misprediction}),
                32'(vecs[i].ectl));
            tick();
        end
        clear_inputs();
        #1;
        chk("table_cnt_flush", 32'(cnt_flush), 3);
        chk("table_cnt_mispred", 32'(cnt_mispred), 1);
        chk("table_cnt_stall", 32'(cnt_stall), 0);

        // Load-use with LOAD_LAT=3: exactly three stall cycles.
        do_reset();
        valid_EX = 1; load_EX = 1; rd_EX = 7; rs2_ID = 7;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("luse_stall_IF", 32'(stall_IF), 32'(i < 3));
            chk("luse_bubble_EX", 32'(bubble_EX), 32'(i < 3));
            tick();
            if (i == 0) clear_inputs();
        end
        chk("luse_cnt_stall", 32'(cnt_stall), 3);

        // MUL/DIV: done arrives on the fifth cycle, four stall cycles.
        do_reset();
        valid_EX = 1; md_req_EX = 1; md_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) md_done = 1;
            if (i == 5) clear_inputs();
            #1;
            chk("md_stall_EX", 32'(stall_EX), 32'(i < 4));
            chk("md_bubble_MEM", 32'(bubble_MEM), 32'(i < 4));
            chk("md_stall_IF", 32'(stall_IF), 32'(i < 4));
            tick();
        end
        chk("md_cnt_stall", 32'(cnt_stall), 4);

        // Reset in the middle of an MD wait.
        do_reset();
        valid_EX = 1; md_req_EX = 1; md_done = 0;
        tick();
        tick();
        reset = 1;
        tick();
        reset = 0;
        clear_inputs();
        #1;
        chk("mdrst_stall_EX", 32'(stall_EX), 0);
        chk("mdrst_bubble_MEM", 32'(bubble_MEM), 0);
        chk("mdrst_stall_IF", 32'(stall_IF), 0);
        chk("mdrst_cnt_stall", 32'(cnt_stall), 0);
        tick();

        // Saturation on the CNT_W=2 instance: five stall cycles read back as 3.
        do_reset();
        valid_EX = 1; load_EX = 1; rd_EX = 7; rs1_ID = 7;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("sat_stall_IF", 32'(s_sif), 1);
            tick();
        end
        chk("sat_cnt_stall", 32'(s_cnt_stall), 3);
        clear_inputs();
        tick();

        // Randomized stimulus against the model.
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            rs1_ID        = 5'($urandom_range(0, 3));
            rs2_ID        = 5'($urandom_range(0, 3));
            rs1_EX        = 5'($urandom_range(0, 3));
            rs2_EX        = 5'($urandom_range(0, 3));
            rd_EX         = 5'($urandom_range(0, 3));
            rd_MEM        = 5'($urandom_range(0, 3));
            rd_WB         = 5'($urandom_range(0, 3));
            regwrite_MEM  = $urandom_range(0, 1) == 1;
            regwrite_WB   = $urandom_range(0, 1) == 1;
            valid_EX      = $urandom_range(0, 9) < 8;
            load_EX       = $urandom_range(0, 9) < 3;
            md_req_EX     = $urandom_range(0, 9) < 2;
            md_done       = $urandom_range(0, 9) < 3;
            branch_EX     = $urandom_range(0, 9) < 3;
            prediction_EX = $urandom_range(0, 1) == 1;
            btaken_EX     = $urandom_range(0, 1) == 1;
            jal_EX        = $urandom_range(0, 9) == 0;
            jalr_EX       = $urandom_range(0, 19) == 0;
            tick();
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
